// File: rtl/trigger_capture_buffer.sv
// rtl/trigger_capture_buffer.sv - armed ring-buffer capture of pre/post-trigger ADC samples with stream readout
// Optional: define TRIG_TIMESTAMP_EN to add a free-running cycle counter and the trig_ts output.
module trigger_capture_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc,
    input  logic              trig_condition,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W:0]   post_len,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              triggered,
`ifdef TRIG_TIMESTAMP_EN
    output logic [31:0]       trig_ts,
`endif
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]   pre_len_q, pre_len_d;
    logic [ADDR_W:0]     post_q, post_d;
    logic [ADDR_W:0]     post_cnt_q, post_cnt_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic                triggered_q, triggered_d;
    logic                done_q, done_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_valid_q, skid_valid_d;
    logic                skid_last_q, skid_last_d;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]         ts_cnt_q, ts_cnt_d;
    logic [31:0]         trig_ts_q, trig_ts_d;
`endif

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
    logic                we, rd_en, pop, out_free;
    logic [ADDR_W:0]     post_eff, room, post_clamped, total;
    logic [1:0]          occ;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        pre_len_d    = pre_len_q;
        post_d       = post_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        triggered_d  = triggered_q;
        done_d       = 1'b0;
        we           = 1'b0;
        rd_en        = 1'b0;
`ifdef TRIG_TIMESTAMP_EN
        ts_cnt_d     = ts_cnt_q + 32'd1;
        trig_ts_d    = trig_ts_q;
`endif
        post_eff     = (post_len == '0) ? {{ADDR_W{1'b0}}, 1'b1} : post_len;
        room         = DEPTH - {1'b0, pre_len};
        post_clamped = (post_eff > room) ? room : post_eff;
        total        = {1'b0, pre_len_q} + post_q;
        pop          = m_valid_q && m_ready;
        occ          = 2'(m_valid_q) + 2'(skid_valid_q) + 2'(rvalid_q);

        case (state_q)
            IDLE: begin
                if (arm) begin
                    pre_len_d  = pre_len;
                    post_d     = post_clamped;
                    fill_cnt_d = '0;
                    state_d    = (pre_len == '0) ? ARMED : FILL;
                end
            end
            FILL: begin
                we         = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_d == pre_len_q) state_d = ARMED;
            end
            ARMED: begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (trig_condition) begin
                    triggered_d = 1'b1;
                    post_cnt_d  = {{ADDR_W{1'b0}}, 1'b1};
                    rd_ptr_d    = wr_ptr_q - pre_len_q;
                    rd_cnt_d    = '0;
                    state_d     = (post_q == {{ADDR_W{1'b0}}, 1'b1}) ? READOUT : POST;
`ifdef TRIG_TIMESTAMP_EN
                    trig_ts_d   = ts_cnt_q;
`endif
                end
            end
            POST: begin
                we         = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                post_cnt_d = post_cnt_q + 1'b1;
                if (post_cnt_q == post_q - 1'b1) state_d = READOUT;
            end
            READOUT: begin
                // At most two beats may be held or in flight once this cycle's pop is retired.
                if (rd_cnt_q != total && occ <= 2'd1 + 2'(pop)) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (pop && m_last_q) begin
                    done_d      = 1'b1;
                    triggered_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rvalid_d = rd_en;
        rlast_d  = rd_en && (rd_cnt_q == total - 1'b1);

        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        out_free     = !m_valid_q || m_ready;
        if (out_free) begin
            if (skid_valid_q) begin
                m_data_d     = skid_data_q;
                m_last_d     = skid_last_q;
                m_valid_d    = 1'b1;
                skid_valid_d = rvalid_q;
                skid_data_d  = rdata_q;
                skid_last_d  = rlast_q;
            end else if (rvalid_q) begin
                m_data_d  = rdata_q;
                m_last_d  = rlast_q;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        end else if (rvalid_q) begin
            skid_data_d  = rdata_q;
            skid_last_d  = rlast_q;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= adc;
        if (rd_en) rdata_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            pre_len_q    <= '0;
            post_q       <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
`ifdef TRIG_TIMESTAMP_EN
            ts_cnt_q     <= '0;
            trig_ts_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            pre_len_q    <= pre_len_d;
            post_q       <= post_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
`ifdef TRIG_TIMESTAMP_EN
            ts_cnt_q     <= ts_cnt_d;
            trig_ts_q    <= trig_ts_d;
`endif
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign done      = done_q;
`ifdef TRIG_TIMESTAMP_EN
    assign trig_ts   = trig_ts_q;
`endif

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// tb/tb_trigger_capture_buffer.sv - directed self-checking bench for trigger_capture_buffer (depth 16)
module tb_trigger_capture_buffer;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, arm, trig, m_ready;
    logic [DW-1:0] adc;
    logic [AW-1:0] pre_len;
    logic [AW:0]   post_len;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, busy, triggered, done;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]   trig_ts;
`endif

    int total = 0;
    int bad = 0;
    int steps = 0;
    int trig_step = 0;

    trigger_capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .adc(adc), .trig_condition(trig), .arm(arm),
        .pre_len(pre_len), .post_len(post_len), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .triggered(triggered),
`ifdef TRIG_TIMESTAMP_EN
        .trig_ts(trig_ts),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        adc = adc + 1'b1;
        steps++;
    endtask

    // Arms with adc=0 in the arm cycle, then raises trig in the cycle where adc == trig_val.
    task automatic start(input int pre, input int post, input int early_val, input int trig_val,
                         output bit tmo, output logic trig_before);
        pre_len = AW'(pre);
        post_len = (AW+1)'(post);
        adc = '0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        tmo = 1'b1;
        trig_before = 1'bx;
        for (int c = 0; c < 300; c++) begin
            trig = (adc == early_val) || (adc == trig_val);
            if (adc == trig_val) begin
                trig_before = triggered;
                trig_step = steps;
                step();
                trig = 1'b0;
                tmo = 1'b0;
                break;
            end
            step();
            trig = 1'b0;
        end
    endtask

    task automatic readout(input int mode, input int arm_cyc, output logic [DW-1:0] d[$], output logic l[$],
                           output int first_v, output int stall_bad, output int ndone,
                           output int late_valid, output bit tmo);
        bit fin = 1'b0;
        bit pstall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        d = {};
        l = {};
        first_v = -1;
        stall_bad = 0;
        ndone = 0;
        late_valid = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            m_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            arm = (c == arm_cyc);
            @(negedge clk);
            if (pstall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_bad++;
            if (m_valid === 1'b1 && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                d.push_back(m_data);
                l.push_back(m_last);
                if (m_last) fin = 1'b1;
            end
            pstall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            step();
        end
        arm = 1'b0;
        m_ready = 1'b1;
        tmo = !fin;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (m_valid) late_valid++;
            step();
        end
    endtask

    task automatic check_frame(input string name, input logic [DW-1:0] d[$], input logic l[$],
                               input int first, input int n);
        total++;
        if (d.size() != n) begin
            bad++;
            $display("FAIL %s frame_len got=%0d exp=%0d", name, d.size(), n);
        end
        for (int i = 0; i < d.size() && i < n; i++) begin
            total++;
            if (d[i] !== DW'(first + i) || l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s beat%0d got=%0d/last=%b exp=%0d/last=%b", name, i, d[i], l[i], first + i, (i == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if ({m_valid, m_last, busy, triggered, done} !== 5'b0 || m_data !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b data=%0d exp=00000 data=0", {m_valid, m_last, busy, triggered, done}, m_data);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv; bit tmo, tmo2; logic tb4;
        start(4, 4, -1, 20, tmo, tb4);
        total++;
        if (tmo || triggered !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_trig got=trig%b busy%b exp=11", triggered, busy);
        end
        readout(0, -1, d, l, fv, sb, nd, lv, tmo2);
        check_frame("basic", d, l, 16, 8);
        total++;
        if (tmo2 || fv != 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", fv); end
        total++;
        if (nd != 1 || lv != 0) begin bad++; $display("FAIL basic_done got=%0d late=%0d exp=1 late=0", nd, lv); end
        total++;
        if (busy !== 1'b0 || triggered !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got=busy%b trig%b exp=00", busy, triggered);
        end
    endtask

    task automatic test_fill_trig_ignored();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv; bit tmo, tmo2; logic tb4;
        start(4, 4, 2, 20, tmo, tb4);
        total++;
        if (tmo || tb4 !== 1'b0) begin bad++; $display("FAIL fill_trig got=%b exp=0", tb4); end
        readout(0, -1, d, l, fv, sb, nd, lv, tmo2);
        check_frame("fill_trig", d, l, 16, 8);
        total++;
        if (tmo2 || nd != 1) begin bad++; $display("FAIL fill_trig_done got=%0d exp=1", nd); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv; bit tmo, tmo2; logic tb4;
        test_reset();
        start(6, 4, -1, 19, tmo, tb4);
        readout(0, -1, d, l, fv, sb, nd, lv, tmo2);
        check_frame("wrap", d, l, 13, 10);
        total++;
        if (tmo || tmo2 || nd != 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", nd); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv; bit tmo, tmo2; logic tb4;
        start(4, 4, -1, 20, tmo, tb4);
        readout(1, 7, d, l, fv, sb, nd, lv, tmo2);
        check_frame("stall", d, l, 16, 8);
        total++;
        if (tmo || tmo2 || sb != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", sb); end
        total++;
        if (nd != 1 || busy !== 1'b0) begin bad++; $display("FAIL stall_end got=done%0d busy%b exp=done1 busy0", nd, busy); end
    endtask

    task automatic test_clamp();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv; bit tmo, tmo2; logic tb4;
        start(12, 10, -1, 20, tmo, tb4);
        readout(0, -1, d, l, fv, sb, nd, lv, tmo2);
        check_frame("clamp", d, l, 8, 16);
        total++;
        if (tmo || tmo2 || nd != 1) begin bad++; $display("FAIL clamp_done got=%0d exp=1", nd); end
    endtask

    task automatic test_reset_mid_post();
        logic [DW-1:0] d[$]; logic l[$];
        int fv, sb, nd, lv, vcnt; bit tmo, tmo2; logic tb4;
        int rst_step;
        start(4, 8, -1, 20, tmo, tb4);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rst_step = steps;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || triggered !== 1'b0) begin
            bad++;
            $display("FAIL abort got=v%b busy%b trig%b exp=000", m_valid, busy, triggered);
        end
        vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_valid) vcnt++;
            step();
        end
        total++;
        if (vcnt != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", vcnt); end
        start(3, 5, -1, 30, tmo, tb4);
`ifdef TRIG_TIMESTAMP_EN
        total++;
        if (trig_ts !== 32'(trig_step - rst_step)) begin
            bad++;
            $display("FAIL trig_ts got=%0d exp=%0d", trig_ts, trig_step - rst_step);
        end
`endif
        readout(0, -1, d, l, fv, sb, nd, lv, tmo2);
        check_frame("rearm", d, l, 27, 8);
        total++;
        if (tmo || tmo2 || nd != 1 || rst_step < 0) begin bad++; $display("FAIL rearm_done got=%0d exp=1", nd); end
    endtask

    initial begin
        reset = 1'b1;
        arm = 1'b0;
        trig = 1'b0;
        m_ready = 1'b1;
        adc = '0;
        pre_len = '0;
        post_len = '0;
        test_reset();
        test_basic();
        test_fill_trig_ignored();
        test_wrap();
        test_backpressure();
        test_clamp();
        test_reset_mid_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
